fa_resp_checker: RTL and testbench

Self-checking response end for the one-bit full_adder: a hardware sweep engine that drives a, b, cin into an external full adder instance and checks the returned sum/cout.
- Runs PASSES exhaustive sweeps of all 8 input vectors.
- Waits SETTLE_CYC cycles per vector, then compares against the golden equations.
- Reports error count, first failing vector, and pass/fail.
- Used on-chip as built-in self-test for adder cells and in regression benches in place of free-running toggle stimulus.

---
 rtl/fa_resp_checker_if.sv | 45 ++++
 rtl/fa_resp_checker.sv | 201 ++++++++++++++++++++
 tb/tb_fa_resp_checker.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fa_resp_checker_if.sv
// fa_resp_checker_if
//   Bundles the stimulus/response and status signals between the full-adder
//   response checker and its environment.
//
//   Parameter:
//     ERR_W            width of the error counter
//
//   Signals:
//     start            one-cycle request to begin a run
//     dut_sum/dut_cout response from the adder under test
//     a/b/cin          operands driven to the adder under test
//     busy/done/pass   run status
//     err_cnt          saturating mismatch count of the last run
//     first_fail_vld   a mismatch was captured in the last run
//     first_fail_vec   {cin,b,a} of the first mismatching vector
//
//   Modports:
//     master           environment side (drives start and the adder response)
//     slave            checker side
interface fa_resp_checker_if #(
    parameter int unsigned ERR_W = 8
);
    logic             start;
    logic             dut_sum;
    logic             dut_cout;
    logic             a;
    logic             b;
    logic             cin;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             first_fail_vld;
    logic [2:0]       first_fail_vec;

    modport master (
        output start, dut_sum, dut_cout,
        input  a, b, cin, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec
    );

    modport slave (
        input  start, dut_sum, dut_cout,
        output a, b, cin, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec
    );
endinterface

// File: rtl/fa_resp_checker.sv
// fa_resp_checker
//   Built-in self-test sweep engine for a one-bit full adder. Drives all 8
//   {cin,b,a} vectors PASSES times, waits SETTLE_CYC cycles per vector, then
//   compares the returned sum/cout against the golden equations. Reports a
//   saturating error count, the first failing vector and a pass flag.
//
//   Parameters:
//     SETTLE_CYC  wait cycles between driving a vector and sampling (0 allowed)
//     PASSES      full 8-vector sweeps per run (>= 1)
//     ERR_W       width of the saturating error counter
//
//   Ports:
//     clk         system clock, rising edge
//     rst         asynchronous, active-high reset
//     bus         fa_resp_checker_if.slave (start, adder response, operands, status)
//
//   Build option:
//     FA_CHK_STOP_ON_FAIL_EN  when defined, the first mismatch ends the run
//                             and a/b/cin keep the failing vector.
module fa_resp_checker #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned PASSES     = 1,
    parameter int unsigned ERR_W      = 8
) (
    input logic              clk,
    input logic              rst,
    fa_resp_checker_if.slave bus
);

    localparam int unsigned SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'((PASSES > 0) ? PASSES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_idx;
    logic [PC_W-1:0]  r_pass_cnt;
    logic [SC_W-1:0]  r_settle;
    logic             r_a;
    logic             r_b;
    logic             r_cin;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_ff_vld;
    logic [2:0]       r_ff_vec;

    logic             w_accept;
    logic             w_drive;
    logic             w_check;
    logic             w_finish;
    logic             w_mismatch;
    logic             w_exp_sum;
    logic             w_exp_cout;

    // Golden response is taken from the registered operands, i.e. exactly
    // what the adder under test is currently seeing.
    assign w_exp_sum  = r_a ^ r_b ^ r_cin;
    assign w_exp_cout = (r_a & r_b) | (r_a & r_cin) | (r_b & r_cin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drive     = 1'b0;
        w_check     = 1'b0;
        w_finish    = 1'b0;
        w_mismatch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_drive     = 1'b1;
                w_state_nxt = (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle == SC_LAST) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_check    = 1'b1;
                w_mismatch = (bus.dut_sum != w_exp_sum) || (bus.dut_cout != w_exp_cout);
                if ((r_idx != 3'd7) || (r_pass_cnt != PC_LAST)) begin
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_state_nxt = S_DONE;
                end
`ifdef FA_CHK_STOP_ON_FAIL_EN
                if (w_mismatch) begin
                    w_state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_settle   <= '0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_cin      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_vec   <= '0;
        end else begin
            // done is registered off the DONE state so it lands one cycle
            // after the final check, together with busy falling.
            r_done <= w_finish;

            if (w_accept) begin
                r_idx      <= '0;
                r_pass_cnt <= '0;
                r_busy     <= 1'b1;
                r_pass     <= 1'b0;
                r_err_cnt  <= '0;
                r_ff_vld   <= 1'b0;
                r_ff_vec   <= '0;
            end

            if (w_drive) begin
                r_a      <= r_idx[0];
                r_b      <= r_idx[1];
                r_cin    <= r_idx[2];
                r_settle <= '0;
            end

            if (r_state == S_SETTLE) begin
                r_settle <= r_settle + 1'b1;
            end

            if (w_check) begin
                // idx wraps 7 -> 0 on its own; the pass counter steps with it.
                r_idx <= r_idx + 3'd1;
                if (r_idx == 3'd7) begin
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                end
                if (w_mismatch) begin
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    if (!r_ff_vld) begin
                        r_ff_vld <= 1'b1;
                        r_ff_vec <= {r_cin, r_b, r_a};
                    end
                end
            end

            if (w_finish) begin
                r_busy <= 1'b0;
                r_pass <= (r_err_cnt == '0);
            end
        end
    end

    assign bus.a              = r_a;
    assign bus.b              = r_b;
    assign bus.cin            = r_cin;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_cnt        = r_err_cnt;
    assign bus.first_fail_vld = r_ff_vld;
    assign bus.first_fail_vec = r_ff_vec;

endmodule

// File: tb/tb_fa_resp_checker.sv
// tb_fa_resp_checker
//   Scoreboard bench for fa_resp_checker. Two instances:
//     u_a : SETTLE_CYC=2, PASSES=1, ERR_W=8
//     u_b : SETTLE_CYC=0, PASSES=2, ERR_W=2
//   Each accepted start pushes a hand-computed expected result; a monitor per
//   instance pops and compares on every done pulse.
module tb_fa_resp_checker;

    localparam int PERIOD = 10;
    localparam int HALF   = 5;

    typedef struct {
        int     err;
        int     pass;
        int     ffv;
        int     vec;
        int     lat;
        int     abc;
        longint t0;
    } exp_t;

    logic clk;
    logic rst;
    int   mode_a;
    int   mode_b;
    int   total;
    int   bad;
    exp_t qa[$];
    exp_t qb[$];

    fa_resp_checker_if #(.ERR_W(8)) ifa ();
    fa_resp_checker_if #(.ERR_W(2)) ifb ();

    fa_resp_checker #(.SETTLE_CYC(2), .PASSES(1), .ERR_W(8)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    fa_resp_checker #(.SETTLE_CYC(0), .PASSES(2), .ERR_W(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Adder models: 0 = correct, 1 = sum stuck at 0, 2 = cout inverted.
    assign ifa.dut_sum  = (mode_a == 1) ? 1'b0 : (ifa.a ^ ifa.b ^ ifa.cin);
    assign ifa.dut_cout = ((ifa.a & ifa.b) | (ifa.a & ifa.cin) | (ifa.b & ifa.cin)) ^ (mode_a == 2);
    assign ifb.dut_sum  = (mode_b == 1) ? 1'b0 : (ifb.a ^ ifb.b ^ ifb.cin);
    assign ifb.dut_cout = ((ifb.a & ifb.b) | (ifb.a & ifb.cin) | (ifb.b & ifb.cin)) ^ (mode_b == 2);

    initial clk = 1'b0;
    always #(HALF) clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: one pop per done pulse.
    always @(negedge clk) begin
        if (!rst && ifa.done) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_latency", ($time - HALF - e.t0) / PERIOD, e.lat);
                chk("a_err_cnt", ifa.err_cnt, e.err);
                chk("a_pass", ifa.pass, e.pass);
                chk("a_ff_vld", ifa.first_fail_vld, e.ffv);
                chk("a_ff_vec", ifa.first_fail_vec, e.vec);
                chk("a_busy_at_done", ifa.busy, 0);
                chk("a_abc_hold", {ifa.cin, ifa.b, ifa.a}, e.abc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ifb.done) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_latency", ($time - HALF - e.t0) / PERIOD, e.lat);
                chk("b_err_cnt", ifb.err_cnt, e.err);
                chk("b_pass", ifb.pass, e.pass);
                chk("b_ff_vld", ifb.first_fail_vld, e.ffv);
                chk("b_ff_vec", ifb.first_fail_vec, e.vec);
                chk("b_busy_at_done", ifb.busy, 0);
                chk("b_abc_hold", {ifb.cin, ifb.b, ifb.a}, e.abc);
            end
        end
    end

    // Pulse start for one cycle; push the expectation when it is meant to be
    // accepted. Returns on the negedge right after the sampling edge.
    task automatic pulse(input int which, input int mode, input bit push, input exp_t e);
        @(negedge clk);
        e.t0 = $time + HALF;
        if (which == 0) begin
            mode_a = mode;
            ifa.start = 1'b1;
            if (push) qa.push_back(e);
        end else begin
            mode_b = mode;
            ifb.start = 1'b1;
            if (push) qb.push_back(e);
        end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int left;
        left = (which == 0) ? qa.size() : qb.size();
        for (int i = 0; i < budget && left != 0; i++) begin
            @(negedge clk);
            #1;
            left = (which == 0) ? qa.size() : qb.size();
        end
        if (left != 0) begin
            chk(which == 0 ? "a_done_timeout" : "b_done_timeout", left, 0);
            if (which == 0) qa.delete(); else qb.delete();
        end
    endtask

    function automatic exp_t mk(input int err, input int pass, input int ffv,
                                input int vec, input int lat, input int abc);
        exp_t e;
        e.err = err; e.pass = pass; e.ffv = ffv; e.vec = vec;
        e.lat = lat; e.abc = abc; e.t0 = 0;
        return e;
    endfunction

    initial begin
        exp_t e;
        int   m;
        total     = 0;
        bad       = 0;
        mode_a    = 0;
        mode_b    = 0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_a_outs", {ifa.a, ifa.b, ifa.cin, ifa.busy, ifa.done, ifa.pass,
                             ifa.first_fail_vld, ifa.first_fail_vec}, 0);
        chk("reset_a_err", ifa.err_cnt, 0);
        chk("reset_b_outs", {ifb.a, ifb.b, ifb.cin, ifb.busy, ifb.done, ifb.pass,
                             ifb.first_fail_vld, ifb.first_fail_vec}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: clean sweep on A, walk a/b/cin through idx 0..7.
        pulse(0, 0, 1'b1, mk(0, 1, 0, 0, 33, 7));
        chk("a_busy_after_start", ifa.busy, 1);
        m = 0;
        for (int k = 0; k < 8; k++) begin
            repeat (4 * k + 2 - m) @(negedge clk);
            m = 4 * k + 2;
            chk("a_walk_abc", {ifa.cin, ifa.b, ifa.a}, k);
        end
        wait_done(0, 60);
        repeat (3) @(negedge clk);
        chk("a_pass_hold_idle", ifa.pass, 1);

        // 2: sum stuck at 0 -> mismatches at idx 1,2,4,7.
`ifdef FA_CHK_STOP_ON_FAIL_EN
        pulse(0, 1, 1'b1, mk(1, 0, 1, 1, 9, 1));
`else
        pulse(0, 1, 1'b1, mk(4, 0, 1, 1, 33, 7));
`endif
        wait_done(0, 60);
        repeat (2) @(negedge clk);
        chk("a_err_hold_idle", ifa.err_cnt, (qa.size() == 0) ? ifa.err_cnt : 99);

        // 3: cout inverted on B, 16 mismatches, 2-bit counter saturates at 3.
`ifdef FA_CHK_STOP_ON_FAIL_EN
        pulse(1, 2, 1'b1, mk(1, 0, 1, 0, 3, 0));
`else
        pulse(1, 2, 1'b1, mk(3, 0, 1, 0, 33, 7));
`endif
        wait_done(1, 60);
        repeat (2) @(negedge clk);

        // 4: SETTLE_CYC=0 clean run on B, second start mid-run is ignored.
        pulse(1, 0, 1'b1, mk(0, 1, 0, 0, 33, 7));
        repeat (8) @(negedge clk);
        pulse(1, 0, 1'b0, e);
        chk("b_busy_after_ignored_start", ifb.busy, 1);
        wait_done(1, 60);
        repeat (10) @(negedge clk);
        chk("b_single_done_queue", qb.size(), 0);

        // 5: reset during SETTLE of idx 5 on A, then a fresh clean run.
        pulse(0, 0, 1'b1, mk(0, 1, 0, 0, 33, 7));
        repeat (21) @(negedge clk);
        chk("a_abc_idx5", {ifa.cin, ifa.b, ifa.a}, 5);
        chk("a_busy_idx5", ifa.busy, 1);
        rst = 1'b1;
        #1;
        chk("a_midrst_outs", {ifa.a, ifa.b, ifa.cin, ifa.busy, ifa.done, ifa.pass,
                              ifa.first_fail_vld, ifa.first_fail_vec}, 0);
        chk("a_midrst_err", ifa.err_cnt, 0);
        qa.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("a_no_done_after_abort", ifa.busy, 0);
        pulse(0, 0, 1'b1, mk(0, 1, 0, 0, 33, 7));
        wait_done(0, 60);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
